spmv_row_ctrl: RTL and testbench

Row sequencer that sits directly upstream of the SpMV multiply-accumulate unit. It consumes a CSR row-length stream and a stream of pre-gathered (matrix value, x element) pairs, and drives the MAC's operand and accumulator-clear handshakes. It collects the accumulated dot product at each row boundary and emits one result per row, tagged with its row index, to the downstream writer.

---
 rtl/spmv_pkg.sv | 22 ++
 rtl/spmv_row_ctrl.sv | 176 +++++++++++++++++
 tb/tb_spmv_row_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spmv_pkg.sv
// Shared types and default widths for the SpMV row datapath.
// Used by spmv_row_ctrl and by the downstream result writer.
package spmv_pkg;

    localparam int SPMV_DATA_WIDTH    = 32;
    localparam int SPMV_ROW_LEN_WIDTH = 16;
    localparam int SPMV_ROW_IDX_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FEED   = 3'd2,
        DRAIN  = 3'd3,
        RESULT = 3'd4
    } row_ctrl_state_e;

    typedef struct packed {
        logic [SPMV_ROW_IDX_WIDTH-1:0]  row;
        logic [2*SPMV_DATA_WIDTH-1:0]   data;
    } spmv_result_t;

endpackage

// File: rtl/spmv_row_ctrl.sv
// SpMV row sequencer: clears the MAC, streams one row of operands into it and
// emits the accumulated result tagged with its row index. Optional perf
// counters are built when SPMV_ROW_CTRL_PERF_EN is defined.
module spmv_row_ctrl
    import spmv_pkg::*;
#(
    parameter int DATA_WIDTH    = SPMV_DATA_WIDTH,
    parameter int ROW_LEN_WIDTH = SPMV_ROW_LEN_WIDTH,
    parameter int ROW_IDX_WIDTH = SPMV_ROW_IDX_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ROW_LEN_WIDTH-1:0]   row_len,
    input  logic                       row_valid,
    output logic                       row_ready,
    input  logic [2*DATA_WIDTH-1:0]    elem_val,
    input  logic [DATA_WIDTH-1:0]      elem_x,
    input  logic                       elem_valid,
    output logic                       elem_ready,
    output logic [2*DATA_WIDTH-1:0]    mac_val,
    output logic [DATA_WIDTH-1:0]      mac_mult,
    output logic                       mac_in_valid,
    input  logic                       mac_in_ready,
    output logic                       mac_reset,
    input  logic                       mac_done,
    input  logic [2*DATA_WIDTH-1:0]    mac_acc,
    input  logic                       mac_valid,
    output logic                       mac_ready,
    output logic [2*DATA_WIDTH-1:0]    res_data,
    output logic [ROW_IDX_WIDTH-1:0]   res_row,
    output logic                       res_valid,
    input  logic                       res_ready,
`ifdef SPMV_ROW_CTRL_PERF_EN
    output logic [31:0]                perf_rows,
    output logic [31:0]                perf_stall,
`endif
    output logic [2:0]                 dbg_state
);

    // Every handshake here is valid/ready: a transfer happens on a rising clk
    // edge where both are high; the source holds its payload until then.

    localparam int OUT_W = ROW_LEN_WIDTH + 1;
    localparam logic [ROW_LEN_WIDTH-1:0] LEN_ZERO = '0;
    localparam logic [ROW_LEN_WIDTH-1:0] LEN_ONE  = {{(ROW_LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0]         OUT_ONE  = {{(OUT_W-1){1'b0}}, 1'b1};
    localparam logic [ROW_IDX_WIDTH-1:0] ROW_ONE  = {{(ROW_IDX_WIDTH-1){1'b0}}, 1'b1};

    row_ctrl_state_e              state_q;
    logic [ROW_LEN_WIDTH-1:0]     remaining_q;
    logic [OUT_W-1:0]             outstanding_q;
    logic [OUT_W-1:0]             outstanding_d;
    logic [2*DATA_WIDTH-1:0]      res_data_q;
    logic [ROW_IDX_WIDTH-1:0]     res_row_q;
    logic                         row_ready_q;
    logic                         mac_reset_q;
    logic                         res_valid_q;

    logic in_feed;
    logic op_hs;
    logic done_hs;
    logic drain_hs;

    assign in_feed      = (state_q == FEED);
    assign mac_in_valid = in_feed && elem_valid;
    assign elem_ready   = in_feed && mac_in_ready;
    assign mac_val      = elem_val;
    assign mac_mult     = elem_x;
    assign op_hs        = in_feed && elem_valid && mac_in_ready;
    assign done_hs      = mac_done && (state_q == FEED || state_q == DRAIN);
    // The result is only taken once every issued operand has been acknowledged.
    assign mac_ready    = (state_q == DRAIN) && (outstanding_q == '0);
    assign drain_hs     = mac_ready && mac_valid;

    assign row_ready = row_ready_q;
    assign mac_reset = mac_reset_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_row   = res_row_q;
    assign dbg_state = state_q;

    always_comb begin
        outstanding_d = outstanding_q;
        if (op_hs && !done_hs) begin
            outstanding_d = outstanding_q + OUT_ONE;
        end else if (done_hs && !op_hs && outstanding_q != '0) begin
            outstanding_d = outstanding_q - OUT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            remaining_q   <= '0;
            outstanding_q <= '0;
            res_data_q    <= '0;
            res_row_q     <= '0;
            row_ready_q   <= 1'b1;
            mac_reset_q   <= 1'b0;
            res_valid_q   <= 1'b0;
        end else begin
            mac_reset_q   <= 1'b0;
            outstanding_q <= outstanding_d;
            case (state_q)
                IDLE: begin
                    if (row_valid) begin
                        remaining_q <= row_len;
                        row_ready_q <= 1'b0;
                        if (row_len == LEN_ZERO) begin
                            res_data_q  <= '0;
                            res_valid_q <= 1'b1;
                            state_q     <= RESULT;
                        end else begin
                            mac_reset_q <= 1'b1;
                            state_q     <= CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    if (mac_done) begin
                        state_q <= FEED;
                    end
                end
                FEED: begin
                    if (op_hs) begin
                        remaining_q <= remaining_q - LEN_ONE;
                        if (remaining_q == LEN_ONE) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_hs) begin
                        res_data_q  <= mac_acc;
                        res_valid_q <= 1'b1;
                        state_q     <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        row_ready_q <= 1'b1;
                        res_row_q   <= res_row_q + ROW_ONE;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SPMV_ROW_CTRL_PERF_EN
    logic [31:0] perf_rows_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_rows_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (state_q == RESULT && res_ready && perf_rows_q != '1) begin
                perf_rows_q <= perf_rows_q + 32'd1;
            end
            if (in_feed && elem_valid && !mac_in_ready && perf_stall_q != '1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_rows  = perf_rows_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_spmv_row_ctrl.sv
// Bench for spmv_row_ctrl: table of rows with hand-derived results, corner
// sequences (stall, ready toggling, mid-row reset, tag wrap) and random rows.
module tb_spmv_row_ctrl;
    import spmv_pkg::*;

    localparam int DW = 32;
    localparam int LW = 16;
    localparam int IW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [LW-1:0]   row_len = '0;
    logic            row_valid = 1'b0;
    logic            row_ready;
    logic [2*DW-1:0] elem_val = '0;
    logic [DW-1:0]   elem_x = '0;
    logic            elem_valid = 1'b0;
    logic            elem_ready;
    logic [2*DW-1:0] mac_val;
    logic [DW-1:0]   mac_mult;
    logic            mac_in_valid;
    logic            mac_in_ready = 1'b1;
    logic            mac_reset;
    logic            mac_done;
    logic [2*DW-1:0] mac_acc;
    logic            mac_valid = 1'b1;
    logic            mac_ready;
    logic [2*DW-1:0] res_data;
    logic [IW-1:0]   res_row;
    logic            res_valid;
    logic            res_ready = 1'b1;
    logic [2:0]      dbg_state;

    // Second instance with a 2-bit tag sees identical stimulus.
    logic            row_ready_2, elem_ready_2, mac_in_valid_2, mac_reset_2, mac_ready_2, res_valid_2;
    logic [2*DW-1:0] mac_val_2, res_data_2;
    logic [DW-1:0]   mac_mult_2;
    logic [1:0]      res_row_2;
    logic [2:0]      dbg_state_2;
`ifdef SPMV_ROW_CTRL_PERF_EN
    logic [31:0] perf_rows, perf_stall, perf_rows_2, perf_stall_2;
`endif

    spmv_row_ctrl #(.DATA_WIDTH(DW), .ROW_LEN_WIDTH(LW), .ROW_IDX_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .row_len(row_len), .row_valid(row_valid), .row_ready(row_ready),
        .elem_val(elem_val), .elem_x(elem_x), .elem_valid(elem_valid), .elem_ready(elem_ready),
        .mac_val(mac_val), .mac_mult(mac_mult), .mac_in_valid(mac_in_valid), .mac_in_ready(mac_in_ready),
        .mac_reset(mac_reset), .mac_done(mac_done), .mac_acc(mac_acc), .mac_valid(mac_valid),
        .mac_ready(mac_ready), .res_data(res_data), .res_row(res_row), .res_valid(res_valid),
        .res_ready(res_ready),
`ifdef SPMV_ROW_CTRL_PERF_EN
        .perf_rows(perf_rows), .perf_stall(perf_stall),
`endif
        .dbg_state(dbg_state)
    );

    spmv_row_ctrl #(.DATA_WIDTH(DW), .ROW_LEN_WIDTH(LW), .ROW_IDX_WIDTH(2)) dut_w2 (
        .clk(clk), .rst(rst), .row_len(row_len), .row_valid(row_valid), .row_ready(row_ready_2),
        .elem_val(elem_val), .elem_x(elem_x), .elem_valid(elem_valid), .elem_ready(elem_ready_2),
        .mac_val(mac_val_2), .mac_mult(mac_mult_2), .mac_in_valid(mac_in_valid_2), .mac_in_ready(mac_in_ready),
        .mac_reset(mac_reset_2), .mac_done(mac_done), .mac_acc(mac_acc), .mac_valid(mac_valid),
        .mac_ready(mac_ready_2), .res_data(res_data_2), .res_row(res_row_2), .res_valid(res_valid_2),
        .res_ready(res_ready),
`ifdef SPMV_ROW_CTRL_PERF_EN
        .perf_rows(perf_rows_2), .perf_stall(perf_stall_2),
`endif
        .dbg_state(dbg_state_2)
    );

    // Behavioural integer MAC; deliberately not cleared by rst.
    logic [63:0] acc = '0;
    logic        done_q = 1'b0;
    always @(posedge clk) begin
        done_q <= (mac_in_valid && mac_in_ready) || mac_reset;
        if (mac_reset) acc <= '0;
        else if (mac_in_valid && mac_in_ready) acc <= acc + mac_val * {32'b0, mac_mult};
    end
    assign mac_done = done_q;
    assign mac_acc  = acc;

    typedef struct { logic [63:0] v; logic [31:0] x; } elem_t;
    typedef struct { int len; logic [63:0] exp_data; } vec_t;

    elem_t       elem_q[$];
    int          row_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] exp_row_q[$];
    logic [31:0] tag = '0;
    bit          mac_pat[$];

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    bit rnd_mode = 0;
    int res_hold = 0;
    bit row_hs, elem_hs, res_hs;
    bit hold_pending = 0, chk_rr = 0, rv_prev = 0;
    logic [63:0] prev_data, last_data;
    logic [31:0] prev_row, last_row;
    logic [1:0]  last_row2;
    int cur_len = 0, cur_ops = 0;
    int resets_seen = 0, ops_seen = 0, inval_seen = 0, stall_seen = 0;
    int row_acc_cyc = 0, rv_rise_cyc = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Reference model: a row's result is the plain sum of its products, tags count up.
    task automatic add_row(input int len, input int mode);
        logic [63:0] sum;
        elem_t e;
        sum = '0;
        for (int k = 0; k < len; k++) begin
            case (mode)
                0: begin e.v = 64'(2 * k + 1); e.x = 32'(2 * k + 2); end
                1: begin e.v = {$urandom, $urandom}; e.x = $urandom; end
                default: begin e.v = 64'd2; e.x = 32'd2; end
            endcase
            sum = sum + e.v * {32'b0, e.x};
            elem_q.push_back(e);
        end
        row_q.push_back(len);
        exp_q.push_back(sum);
        exp_row_q.push_back(tag);
        tag = tag + 32'd1;
    endtask

    task automatic score();
        logic [63:0] e;
        logic [31:0] t;
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_result: got row %0d data %0h, required no result", res_row, res_data);
        end else begin
            e = exp_q.pop_front();
            t = exp_row_q.pop_front();
            chk("res_data", res_data, e);
            chk("res_row", 64'(res_row), 64'(t));
            chk("res_row_w2", 64'(res_row_2), 64'(t[1:0]));
            chk("res_data_w2", res_data_2, e);
        end
        last_data = res_data;
        last_row  = res_row;
        last_row2 = res_row_2;
        chk_rr = 1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || row_q.size() != 0 || elem_q.size() != 0 || !row_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            $display("FAIL %s_timeout: got %0d results pending, required 0 within 3000 cycles", name, exp_q.size());
        end
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_row_ready"}, 64'(row_ready), 64'd1);
        chk({name, "_elem_ready"}, 64'(elem_ready), 64'd0);
        chk({name, "_mac_in_valid"}, 64'(mac_in_valid), 64'd0);
        chk({name, "_mac_reset"}, 64'(mac_reset), 64'd0);
        chk({name, "_mac_ready"}, 64'(mac_ready), 64'd0);
        chk({name, "_res_valid"}, 64'(res_valid), 64'd0);
        chk({name, "_res_data"}, res_data, 64'd0);
        chk({name, "_res_row"}, 64'(res_row), 64'd0);
        chk({name, "_state"}, 64'(dbg_state), 64'(IDLE));
    endtask

    // Driver and monitor: sample handshakes on negedge, drive #1 after posedge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            row_hs = 0; elem_hs = 0; res_hs = 0;
            if (rst) begin
                hold_pending = 0; chk_rr = 0; rv_prev = 0;
            end else begin
                if (chk_rr) begin chk("row_ready_after_result", 64'(row_ready), 64'd1); chk_rr = 0; end
                if (hold_pending) begin
                    stall_seen++;
                    chk("stall_valid", 64'(res_valid), 64'd1);
                    chk("stall_data", res_data, prev_data);
                    chk("stall_row", 64'(res_row), 64'(prev_row));
                end
                if (mac_reset) resets_seen++;
                if (mac_in_valid) inval_seen++;
                if (mac_in_valid && mac_in_ready) ops_seen++;
                if (res_valid && !rv_prev) rv_rise_cyc = cyc;
                rv_prev = res_valid;
                row_hs  = row_valid && row_ready;
                elem_hs = elem_valid && elem_ready;
                res_hs  = res_valid && res_ready;
                if (row_hs) begin row_acc_cyc = cyc; cur_len = int'(row_len); cur_ops = 0; end
                if (res_hs) score();
                hold_pending = res_valid && !res_ready;
                prev_data = res_data;
                prev_row  = res_row;
            end
            @(posedge clk);
            #1;
            if (!rst) begin
                if (elem_hs) begin
                    cur_ops++;
                    chk("state_after_operand", 64'(dbg_state), (cur_ops < cur_len) ? 64'(FEED) : 64'(DRAIN));
                end
                if (row_hs && row_q.size() > 0) void'(row_q.pop_front());
                if (elem_hs && elem_q.size() > 0) void'(elem_q.pop_front());
            end
            if (rst) begin
                row_valid = 0; elem_valid = 0; mac_in_ready = 1; mac_valid = 1; res_ready = 1;
            end else begin
                if (!row_valid || row_hs) begin
                    row_valid = (row_q.size() > 0) && (!rnd_mode || $urandom_range(0, 3) != 0);
                    if (row_q.size() > 0) row_len = LW'(row_q[0]);
                end
                if (!elem_valid || elem_hs) begin
                    elem_valid = (elem_q.size() > 0) && (!rnd_mode || $urandom_range(0, 3) != 0);
                    if (elem_q.size() > 0) begin elem_val = elem_q[0].v; elem_x = elem_q[0].x; end
                end
                if (dbg_state == FEED && mac_pat.size() > 0) mac_in_ready = mac_pat.pop_front();
                else mac_in_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
                mac_valid = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (res_valid && res_hold > 0) begin res_ready = 0; res_hold--; end
                else res_ready = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000 ns, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int r0, o0, v0, s0;
        elem_t e;
        tbl[0] = '{3, 64'd44};
        tbl[1] = '{0, 64'd0};
        tbl[2] = '{2, 64'd14};
        tbl[3] = '{0, 64'd0};
        tbl[4] = '{1, 64'd2};
        tbl[5] = '{4, 64'd100};

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst = 0;

        for (int i = 0; i < 6; i++) begin
            r0 = resets_seen; o0 = ops_seen; v0 = inval_seen; rv_rise_cyc = -1;
            add_row(tbl[i].len, 0);
            wait_done("tbl");
            chk("tbl_data", last_data, tbl[i].exp_data);
            chk("tbl_row", 64'(last_row), 64'(i));
            chk("tbl_clears", 64'(resets_seen - r0), (tbl[i].len > 0) ? 64'd1 : 64'd0);
            chk("tbl_ops", 64'(ops_seen - o0), 64'(tbl[i].len));
            if (tbl[i].len == 0) begin
                chk("zero_len_latency", 64'(rv_rise_cyc - row_acc_cyc), 64'd1);
                chk("zero_len_no_operand", 64'(inval_seen - v0), 64'd0);
            end
        end

        // Rows 2,0,1 back-to-back with the first result held for 5 cycles.
        s0 = stall_seen;
        res_hold = 5;
        add_row(2, 1); add_row(0, 1); add_row(1, 1);
        wait_done("stall");
        chk("stall_cycles", 64'(stall_seen - s0), 64'd5);
        chk("stall_last_row", 64'(last_row), 64'd8);

        // mac_in_ready toggling while a 4-element row is fed.
        mac_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        o0 = ops_seen;
        add_row(4, 1);
        wait_done("toggle");
        chk("toggle_ops", 64'(ops_seen - o0), 64'd4);

        // Reset after 1 of 3 elements has been issued.
        o0 = ops_seen;
        row_q.push_back(3);
        e.v = 64'd5; e.x = 32'd7;
        elem_q.push_back(e);
        for (int n = 0; n < 100 && ops_seen == o0; n++) @(negedge clk);
        chk("pre_reset_ops", 64'(ops_seen - o0), 64'd1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1;
        row_q.delete(); elem_q.delete(); exp_q.delete(); exp_row_q.delete(); mac_pat.delete();
        tag = '0;
        @(negedge clk);
        check_reset_vals("mid_row_reset");
        @(posedge clk); #1;
        rst = 0;
        add_row(1, 2);
        wait_done("after_reset");
        chk("after_reset_data", last_data, 64'd4);
        chk("after_reset_row", 64'(last_row), 64'd0);

        // Tags 1..4 follow; the 2-bit instance wraps back to 0.
        for (int i = 0; i < 4; i++) add_row(1, 0);
        wait_done("wrap");
        chk("wrap_row", 64'(last_row), 64'd4);
        chk("wrap_row_w2", 64'(last_row2), 64'd0);

        rnd_mode = 1;
        for (int i = 0; i < 40; i++) add_row($urandom_range(0, 5), 1);
        wait_done("random");
        rnd_mode = 0;

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
